fifo_ext: RTL and testbench

FIFO_EXT -- requirements
Module: fifo_ext

---
 rtl/fifo_ext.sv | 107 ++++++++++
 tb/tb_fifo_ext.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_ext.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and first-word-fall-through or registered read.
module fifo_ext #(
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter bit FWFT       = 1'b1,
   parameter int AFULL_THR  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THR = 1
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pull,
   input  logic [WORD_WIDTH-1:0] din,
   output logic [WORD_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  wr_en, rd_en;

   assign empty        = (cnt_q == '0);
   assign full         = (cnt_q == DEPTH_W);
   assign almost_full  = (int'(cnt_q) >= AFULL_THR);
   assign almost_empty = (int'(cnt_q) <= AEMPTY_THR);
   assign count        = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
   assign rd_en = pull & ~empty;
   assign wr_en = push & (~full | rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (push && !wr_en) ovf_d = 1'b1;
         if (pull && empty)  unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately unreset; any write issued while res is low is never exposed.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem_q[wr_ptr_q] <= din;
   end

   generate
      if (FWFT) begin : g_fwft
         assign dout = empty ? '0 : mem_q[rd_ptr_q];
      end else begin : g_reg
         logic [WORD_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or negedge res) begin
            if (!res)       dout_q <= '0;
            else if (flush) dout_q <= '0;
            else if (rd_en) dout_q <= mem_q[rd_ptr_q];
         end
         assign dout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_ext.sv
// Drives one FWFT and one registered-read fifo_ext with identical stimulus and
// compares both against a queue-based model of the FIFO contract.
module tb_fifo_ext;
   logic       clk = 1'b0;
   logic       res, flush, push, pull;
   logic [7:0] din;

   logic [7:0] a_dout, b_dout;
   logic       a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
   logic       b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
   logic [3:0] a_count, b_count;

   int checks = 0;
   int errors = 0;

   byte unsigned q[$];
   bit           m_ovf, m_unf;
   logic [7:0]   m_d0;

   always #5 clk = ~clk;

   fifo_ext #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b1), .AFULL_THR(6), .AEMPTY_THR(1)) u_fw (
      .clk(clk), .res(res), .flush(flush), .push(push), .pull(pull), .din(din),
      .dout(a_dout), .empty(a_empty), .full(a_full), .almost_full(a_af),
      .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf));

   fifo_ext #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b0), .AFULL_THR(6), .AEMPTY_THR(1)) u_rg (
      .clk(clk), .res(res), .flush(flush), .push(push), .pull(pull), .din(din),
      .dout(b_dout), .empty(b_empty), .full(b_full), .almost_full(b_af),
      .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_d0  = 8'h00;
   endtask

   // Model of one clock edge, evaluated from the state before the edge.
   task automatic model_edge(input bit p, input bit l, input logic [7:0] d, input bit f);
      bit rd, wr;
      if (f) begin
         model_reset();
         return;
      end
      rd = l && (q.size() > 0);
      wr = p && ((q.size() < 8) || rd);
      if (l && q.size() == 0) m_unf = 1'b1;
      if (p && !wr) m_ovf = 1'b1;
      if (rd) m_d0 = q.pop_front();
      if (wr) q.push_back(d);
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count_fwft", a_count, n);
      chk("count_reg", b_count, n);
      chk("empty", {a_empty, b_empty}, {2{n == 0}});
      chk("full", {a_full, b_full}, {2{n == 8}});
      chk("almost_full", {a_af, b_af}, {2{n >= 6}});
      chk("almost_empty", {a_ae, b_ae}, {2{n <= 1}});
      chk("overflow", {a_ovf, b_ovf}, {2{m_ovf}});
      chk("underflow", {a_unf, b_unf}, {2{m_unf}});
      if (n > 0) chk("dout_fwft", a_dout, q[0]);
      chk("dout_reg", b_dout, m_d0);
   endtask

   task automatic step(input bit p, input bit l, input logic [7:0] d, input bit f = 1'b0);
      push = p; pull = l; din = d; flush = f;
      @(posedge clk);
      model_edge(p, l, d, f);
      #1;
      check_all();
      push = 1'b0; pull = 1'b0; flush = 1'b0;
   endtask

   initial begin
      int bias;
      res = 1'b0; flush = 1'b0; push = 1'b0; pull = 1'b0; din = 8'h00;
      model_reset();
      @(posedge clk); #1;
      check_all();
      chk("reset_dout_fwft", a_dout, 8'h00);
      @(negedge clk) res = 1'b1;
      #1 check_all();

      // fill, then an overflowing push of 0xEE
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i));
      step(1'b1, 1'b0, 8'hEE);
      // drain plus one underflowing pull
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);
      // push+pull while empty: write only
      step(1'b1, 1'b1, 8'h55);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom));
      // push+pull while full: count holds, no overflow added
      step(1'b1, 1'b1, 8'($urandom));
      while (q.size() > 1) step(1'b0, 1'b1, 8'h00);
      // wrap with one word in flight
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
      chk("pre_flush_count", a_count, 4'd5);
      chk("pre_flush_ovf", a_ovf, 1'b1);
      step(1'b1, 1'b1, 8'hA5, 1'b1);

      // randomized traffic with phased fill/drain bias and rare flushes
      for (int i = 0; i < 400; i++) begin
         bias = ((i / 40) % 2) ? 30 : 75;
         step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
              8'($urandom), $urandom_range(0, 63) == 0);
      end

      // asynchronous reset between edges, then held low across an edge
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
      #3 res = 1'b0;
      model_reset();
      #1 check_all();
      chk("async_dout_fwft", a_dout, 8'h00);
      push = 1'b1; pull = 1'b1; din = 8'h77;
      @(posedge clk); #1;
      check_all();
      push = 1'b0; pull = 1'b0;
      @(negedge clk) res = 1'b1;
      for (int i = 0; i < 30; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
